// File: rtl/clock_disp_pkg.sv
// Shared constants for the clock display scanner:
// segment patterns, digit index map and blink pair encodings.
package clock_disp_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Segment patterns {g,f,e,d,c,b,a} for digits 0..9
   localparam logic [6:0] SEG7 [10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   localparam logic [2:0] IDX_HOUR_H = 3'd0;
   localparam logic [2:0] IDX_HOUR_L = 3'd1;
   localparam logic [2:0] IDX_MIN_H  = 3'd2;
   localparam logic [2:0] IDX_MIN_L  = 3'd3;
   localparam logic [2:0] IDX_SEC_H  = 3'd4;
   localparam logic [2:0] IDX_SEC_L  = 3'd5;

   typedef enum logic [1:0] {
      BLINK_NONE = 2'b00,
      BLINK_HOUR = 2'b01,
      BLINK_MIN  = 2'b10,
      BLINK_SEC  = 2'b11
   } blink_sel_e;

endpackage

// File: rtl/clock_display_scan_bcd_to_seg7.sv
// BCD to 7-segment decoder; codes 10..15 decode to blank.
// Purely combinational.
module bcd_to_seg7
   import clock_disp_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Table lookup for valid digits, blank otherwise
   always_comb begin
      seg = SEG_BLANK;
      if (bcd <= 4'd9) seg = SEG7[bcd];
   end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed 7-segment scanner for the HH.MM.SS clock:
// scan timebase, decode, leading-zero blanking and pair blinking.
module clock_display_scan
   import clock_disp_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int BLINK_FRAMES = 64,
   parameter int LZ_BLANK     = 1
) (
   input  logic       CP,
   input  logic       nCR,
   input  logic       EN,
   input  logic [3:0] HourH,
   input  logic [3:0] HourL,
   input  logic [3:0] MinH,
   input  logic [3:0] MinL,
   input  logic [3:0] SecH,
   input  logic [3:0] SecL,
   input  logic [1:0] BlinkSel,
   output logic [6:0] Seg,
   output logic       Dp,
   output logic [5:0] DigSel
);

   localparam int SW = $clog2(SCAN_DIV);
   localparam int FW = $clog2(BLINK_FRAMES) + 1;
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

   logic [SW-1:0] scan_cnt;
   logic [FW-1:0] frame_cnt;
   logic [2:0]    idx;
   logic          blink_phase;

   logic [3:0]    digit;
   logic [6:0]    dec;
   logic          pair_hit;
   logic          blank;
   logic          lz;
   logic [6:0]    seg_next;
   logic          dp_next;

   // Select the digit addressed by the current scan index
   always_comb begin
      digit = 4'd0;
      case (idx)
         IDX_HOUR_H: digit = HourH;
         IDX_HOUR_L: digit = HourL;
         IDX_MIN_H:  digit = MinH;
         IDX_MIN_L:  digit = MinL;
         IDX_SEC_H:  digit = SecH;
         IDX_SEC_L:  digit = SecL;
         default:    digit = 4'd0;
      endcase
   end

   bcd_to_seg7 u_dec (
      .bcd (digit),
      .seg (dec)
   );

   // Blink pair membership, leading-zero and dp rules
   always_comb begin
      pair_hit = 1'b0;
      case (blink_sel_e'(BlinkSel))
         BLINK_NONE: pair_hit = 1'b0;
         BLINK_HOUR: pair_hit = (idx == IDX_HOUR_H) || (idx == IDX_HOUR_L);
         BLINK_MIN:  pair_hit = (idx == IDX_MIN_H)  || (idx == IDX_MIN_L);
         BLINK_SEC:  pair_hit = (idx == IDX_SEC_H)  || (idx == IDX_SEC_L);
         default:    pair_hit = 1'b0;
      endcase
      blank    = blink_phase && pair_hit;
      lz       = (LZ_BLANK != 0) && (idx == IDX_HOUR_H) && (HourH == 4'd0);
      seg_next = (blank || lz) ? SEG_BLANK : dec;
      dp_next  = !blank && ((idx == IDX_HOUR_L) || (idx == IDX_MIN_L));
   end

   // Scan/frame/blink timebase and registered display outputs
   always_ff @(posedge CP or negedge nCR) begin
      if (!nCR) begin
         scan_cnt    <= '0;
         frame_cnt   <= '0;
         idx         <= IDX_HOUR_H;
         blink_phase <= 1'b0;
         Seg         <= SEG_BLANK;
         Dp          <= 1'b0;
         DigSel      <= 6'd0;
      end else if (!EN) begin
         Seg    <= SEG_BLANK;
         Dp     <= 1'b0;
         DigSel <= 6'd0;
      end else begin
         Seg    <= seg_next;
         Dp     <= dp_next;
         DigSel <= 6'd1 << idx;
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (idx == IDX_SEC_L) begin
               idx <= IDX_HOUR_H;
               if (frame_cnt == FRAME_LAST) begin
                  frame_cnt   <= '0;
                  blink_phase <= !blink_phase;
               end else begin
                  frame_cnt <= frame_cnt + 1'b1;
               end
            end else begin
               idx <= idx + 3'd1;
            end
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan with SCAN_DIV=4,
// BLINK_FRAMES=2; a second instance covers LZ_BLANK=0.
module tb_clock_display_scan;

   logic       CP = 1'b0;
   logic       nCR = 1'b0;
   logic       EN = 1'b0;
   logic [3:0] HourH = 4'd0, HourL = 4'd0, MinH = 4'd0;
   logic [3:0] MinL = 4'd0, SecH = 4'd0, SecL = 4'd0;
   logic [1:0] BlinkSel = 2'b00;
   logic [6:0] Seg, Seg_nz;
   logic       Dp, Dp_nz;
   logic [5:0] DigSel, DigSel_nz;

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] seg_tbl [6] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D};

   clock_display_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2), .LZ_BLANK(1)) dut (
      .CP(CP), .nCR(nCR), .EN(EN),
      .HourH(HourH), .HourL(HourL), .MinH(MinH),
      .MinL(MinL), .SecH(SecH), .SecL(SecL),
      .BlinkSel(BlinkSel),
      .Seg(Seg), .Dp(Dp), .DigSel(DigSel)
   );

   clock_display_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2), .LZ_BLANK(0)) dut_nz (
      .CP(CP), .nCR(nCR), .EN(EN),
      .HourH(HourH), .HourL(HourL), .MinH(MinH),
      .MinL(MinL), .SecH(SecH), .SecL(SecL),
      .BlinkSel(BlinkSel),
      .Seg(Seg_nz), .Dp(Dp_nz), .DigSel(DigSel_nz)
   );

   always #5 CP = ~CP;

   task automatic step();
      @(posedge CP);
      @(negedge CP);
   endtask

   task automatic do_reset();
      EN = 1'b0;
      BlinkSel = 2'b00;
      nCR = 1'b0;
      #1;
      nCR = 1'b1;
   endtask

   task automatic set_digits(input logic [3:0] a, b, c, d, e, f);
      HourH = a; HourL = b; MinH = c; MinL = d; SecH = e; SecL = f;
   endtask

   task automatic test_reset();
      @(negedge CP);
      n_checks++;
      if (Seg !== 7'h00) begin
         n_fail++;
         $display("FAIL reset_seg: got %h want 00", Seg);
      end
      n_checks++;
      if (Dp !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_dp: got %b want 0", Dp);
      end
      n_checks++;
      if (DigSel !== 6'h00) begin
         n_fail++;
         $display("FAIL reset_digsel: got %h want 00", DigSel);
      end
   endtask

   task automatic test_scan();
      logic [5:0] ed;
      int         ix;
      do_reset();
      set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
      EN = 1'b1;
      for (int k = 0; k < 28; k++) begin
         step();
         ix = (k / 4) % 6;
         ed = 6'd1 << ix;
         n_checks++;
         if (DigSel !== ed) begin
            n_fail++;
            $display("FAIL scan_digsel k=%0d: got %h want %h", k, DigSel, ed);
         end
         n_checks++;
         if (Seg !== seg_tbl[ix]) begin
            n_fail++;
            $display("FAIL scan_seg k=%0d: got %h want %h", k, Seg, seg_tbl[ix]);
         end
         n_checks++;
         if (Dp !== (ix == 1 || ix == 3)) begin
            n_fail++;
            $display("FAIL scan_dp k=%0d: got %b want %b", k, Dp, (ix == 1 || ix == 3));
         end
      end
   endtask

   task automatic test_leading_zero();
      logic [6:0] es, en;
      do_reset();
      set_digits(4'd0, 4'd7, 4'd3, 4'd4, 4'd5, 4'd6);
      EN = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         es = (k < 4) ? 7'h00 : 7'h07;
         en = (k < 4) ? 7'h3F : 7'h07;
         n_checks++;
         if (DigSel !== ((k < 4) ? 6'h01 : 6'h02)) begin
            n_fail++;
            $display("FAIL lz_digsel k=%0d: got %h", k, DigSel);
         end
         n_checks++;
         if (Seg !== es) begin
            n_fail++;
            $display("FAIL lz_seg k=%0d: got %h want %h", k, Seg, es);
         end
         n_checks++;
         if (Seg_nz !== en) begin
            n_fail++;
            $display("FAIL nolz_seg k=%0d: got %h want %h", k, Seg_nz, en);
         end
      end
   endtask

   task automatic test_invalid();
      do_reset();
      set_digits(4'd1, 4'd2, 4'd3, 4'hC, 4'd5, 4'd6);
      EN = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         if (k >= 12 && k < 16) begin
            n_checks++;
            if (DigSel !== 6'h08 || Seg !== 7'h00 || Dp !== 1'b1) begin
               n_fail++;
               $display("FAIL invalid k=%0d: got sel %h seg %h dp %b want 08 00 1",
                        k, DigSel, Seg, Dp);
            end
         end else if (k >= 16) begin
            n_checks++;
            if (Seg !== 7'h6D) begin
               n_fail++;
               $display("FAIL invalid_after k=%0d: got %h want 6D", k, Seg);
            end
         end
      end
   endtask

   task automatic test_blink();
      int         fr, ix;
      logic       bl;
      logic [6:0] es;
      logic       edp;
      do_reset();
      set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
      BlinkSel = 2'b10;
      EN = 1'b1;
      for (int k = 0; k < 192; k++) begin
         step();
         fr  = k / 24;
         ix  = (k % 24) / 4;
         bl  = ((fr / 2) % 2 == 1) && (ix == 2 || ix == 3);
         es  = bl ? 7'h00 : seg_tbl[ix];
         edp = !bl && (ix == 1 || ix == 3);
         n_checks++;
         if (Seg !== es || Dp !== edp || DigSel !== (6'd1 << ix)) begin
            n_fail++;
            $display("FAIL blink k=%0d: got seg %h dp %b sel %h want %h %b %h",
                     k, Seg, Dp, DigSel, es, edp, 6'd1 << ix);
         end
      end
   endtask

   task automatic test_enable();
      do_reset();
      set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
      EN = 1'b1;
      for (int k = 0; k < 10; k++) step();
      n_checks++;
      if (DigSel !== 6'h04) begin
         n_fail++;
         $display("FAIL en_pre: got %h want 04", DigSel);
      end
      EN = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         n_checks++;
         if (Seg !== 7'h00 || Dp !== 1'b0 || DigSel !== 6'h00) begin
            n_fail++;
            $display("FAIL en_off k=%0d: got seg %h dp %b sel %h want 00 0 00",
                     k, Seg, Dp, DigSel);
         end
      end
      EN = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         n_checks++;
         if (DigSel !== ((k < 2) ? 6'h04 : 6'h08)) begin
            n_fail++;
            $display("FAIL en_resume k=%0d: got %h want %h",
                     k, DigSel, (k < 2) ? 6'h04 : 6'h08);
         end
      end
      n_checks++;
      if (Seg !== 7'h66) begin
         n_fail++;
         $display("FAIL en_resume_seg: got %h want 66", Seg);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
      EN = 1'b1;
      for (int k = 0; k < 17; k++) step();
      n_checks++;
      if (DigSel !== 6'h10) begin
         n_fail++;
         $display("FAIL ar_pre: got %h want 10", DigSel);
      end
      #1;
      nCR = 1'b0;
      #1;
      n_checks++;
      if (Seg !== 7'h00 || Dp !== 1'b0 || DigSel !== 6'h00) begin
         n_fail++;
         $display("FAIL ar_clear: got seg %h dp %b sel %h want 00 0 00",
                  Seg, Dp, DigSel);
      end
      nCR = 1'b1;
      step();
      n_checks++;
      if (DigSel !== 6'h01 || Seg !== 7'h06) begin
         n_fail++;
         $display("FAIL ar_first: got sel %h seg %h want 01 06", DigSel, Seg);
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_leading_zero();
      test_invalid();
      test_blink();
      test_enable();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clock_display_scan.md
Name: clock_display_scan

Overview:
- Reader-side companion to the hour/minute/second BCD counters of the digital clock.
- Consumes six BCD digits (HH:MM:SS) and drives a time-multiplexed six-digit common-cathode 7-segment display.
- Provides a scan timebase, BCD-to-segment decode, invalid-code blanking, optional leading-zero suppression, and blinking of one digit pair for time-setting mode.
- Sits between the counter chain and the board display pins.

Parameters:
- SCAN_DIV, 1000: CP cycles each digit stays selected; legal range ≥2.
- BLINK_FRAMES, 64: full 6-digit frames per blink half-period; legal range ≥1.
- LZ_BLANK, 1: 1 = blank the hour tens digit when it is 0.

Ports:
- CP  in  1  system clock, rising edge.
- nCR  in  1  asynchronous active-low clear.
- EN  in  1  display enable; 0 = blank and freeze.
- HourH  in  4  hour tens digit, BCD.
- HourL  in  4  hour ones digit, BCD.
- MinH  in  4  minute tens digit, BCD.
- MinL  in  4  minute ones digit, BCD.
- SecH  in  4  second tens digit, BCD.
- SecL  in  4  second ones digit, BCD.
- BlinkSel  in  2  00 none, 01 hours, 10 minutes, 11 seconds.
- Seg  out  7  segments {g,f,e,d,c,b,a}, active high.
- Dp  out  1  decimal point / colon, active high.
- DigSel  out  6  one-hot digit enable, active high; bit0 = HourH … bit5 = SecL.

Behaviour:
- Interface: single clock CP; reset nCR is asynchronous and active-low.
- Reset (nCR=0, asynchronous): Seg=0, Dp=0, DigSel=0. Internal digit index=0, scan counter=0, frame counter=0, blink phase=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Scan counter runs 0..SCAN_DIV-1 on each enabled CP edge. At terminal count it wraps to 0 and the index advances 0→1→…→5→0.
- Each index 5→0 wrap increments the frame counter. On that counter's wrap at BLINK_FRAMES-1, the blink phase toggles.
- First enabled CP edge after reset: DigSel=6'b000001, showing HourH.
- Each DigSel value is held exactly SCAN_DIV cycles. DigSel is never multi-hot and never zero while EN=1.
- Seg on each enabled edge is the decode of the currently selected digit input sampled at that edge. A digit input change appears on Seg 1 CP later while that digit is selected.
- Decode 0–9 (gfedcba): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F.
- Digit values 10–15: Seg=0, no error flag.
- Leading zero: if LZ_BLANK=1, HourH==0 and index 0, then Seg=0. DigSel still asserts bit0.
- Blink: when blink phase=1 and the current index belongs to the BlinkSel pair, Seg=0 and Dp=0.
  - Pairs: 01 → idx 0,1; 10 → idx 2,3; 11 → idx 4,5.
  - When blink phase=0, or BlinkSel=00, these digits display normally.
- Dp=1 at indices 1 and 3 (HH.MM.SS separators), subject to blink; Dp=0 at all other indices.
- EN=0:
  - Next edge sets Seg=0, Dp=0, DigSel=0.
  - Scan, frame and blink counters hold their values.
  - On re-enable, scanning resumes from the held index and count; the first re-enabled edge drives that index.
- BlinkSel changes take effect on the next CP edge and do not reset the blink phase.
- nCR asserted mid-scan clears everything immediately, independent of CP.
- Counter widths: $clog2(SCAN_DIV) and $clog2(BLINK_FRAMES)+1 bits. No wrap beyond the stated terminal counts.

Decomposition:
- Shared package clock_disp_pkg holds:
  - SEG7 constant array for 0–9 plus SEG_BLANK;
  - digit index constants IDX_HOUR_H..IDX_SEC_L;
  - BlinkSel encodings BLINK_NONE/HOUR/MIN/SEC.
- One natural sub-module: bcd_to_seg7 (4-bit BCD in, 7-bit segments out, blank for ≥10), purely combinational.
- Scan/blink timing and the output registers stay in the top level.

Test Plan (SCAN_DIV=4, BLINK_FRAMES=2, LZ_BLANK=1 unless stated):
- Reset, then EN=1 with digits 1,2,3,4,5,6 → DigSel 01,02,04,08,10,20,01… each held 4 CP; Seg 06,5B,4F,66,6D,7D; Dp=1 only while DigSel=02 or 08.
- HourH=0, HourL=7 → Seg=00 while DigSel=01 and 07 while DigSel=02. Repeat with LZ_BLANK=0 → Seg=3F at DigSel=01.
- MinL=4'hC → Seg=00 while DigSel=08; Dp still 1 there.
- BlinkSel=10 → frames 0–1 show minutes normally; frames 2–3 give Seg=00 and Dp=0 at DigSel=04/08; hours and seconds unaffected; pattern repeats every 4 frames (96 CP).
- EN=0 mid-digit (DigSel=04, count 2) for 10 CP → outputs 0 for all 10 CP. EN=1 → DigSel=04 for the remaining 2 CP, then 08.
- nCR pulsed low between CP edges while DigSel=10 → Seg/Dp/DigSel=0 immediately. First edge after release gives DigSel=01.
